// File: rtl/veritune_recorder_if.sv
// veritune_recorder_if: command, sample and playback signals of the Veritune recorder.
// The master modport belongs to the controlling side (codec/sequencer). The slave modport
// belongs to the recorder.
//   Rec/Stop/Play/Loop   level commands to the recorder
//   Sample_En/Audio_In   sample strobe and the sample to record
//   Rate                 Q2.FRAC_W playback phase increment
//   Shift_Start/Done     pitch-shift engine handshake
//   Audio_Out/Out_Valid  playback sample and its update pulse
//   Length/Full          recording length, buffer-full flag
//   q_*                  one-hot state view
interface veritune_recorder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned FRAC_W = 8
) ();
  logic              Rec;
  logic              Stop;
  logic              Play;
  logic              Loop;
  logic              Sample_En;
  logic [DATA_W-1:0] Audio_In;
  logic [FRAC_W+1:0] Rate;
  logic              Shift_Done;
  logic              Shift_Start;
  logic [DATA_W-1:0] Audio_Out;
  logic              Out_Valid;
  logic [ADDR_W:0]   Length;
  logic              Full;
  logic              q_I;
  logic              q_Rec;
  logic              q_Stop;
  logic              q_Shift;
  logic              q_Play;

  modport master (
    output Rec, Stop, Play, Loop, Sample_En, Audio_In, Rate, Shift_Done,
    input  Shift_Start, Audio_Out, Out_Valid, Length, Full,
    input  q_I, q_Rec, q_Stop, q_Shift, q_Play
  );

  modport slave (
    input  Rec, Stop, Play, Loop, Sample_En, Audio_In, Rate, Shift_Done,
    output Shift_Start, Audio_Out, Out_Valid, Length, Full,
    output q_I, q_Rec, q_Stop, q_Shift, q_Play
  );
endinterface

// File: rtl/veritune_recorder.sv
// veritune_recorder: record / pitch-shift handoff / fractional-rate playback controller.
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous active-low reset
//   bus    veritune_recorder_if slave (commands, samples, shift handshake, playback out)
// The buffer holds 2^ADDR_W samples. Recording stops by itself when the buffer fills.
// Playback walks a phase accumulator P. The read address is P >> FRAC_W.
module veritune_recorder #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned FRAC_W = 8
) (
  input logic                  Clk,
  input logic                  Reset,
  veritune_recorder_if.slave   bus
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned PW    = ADDR_W + FRAC_W + 1;

  // One-hot state encoding: the bits map directly onto the q_* outputs.
  localparam logic [4:0] StI     = 5'b00001;
  localparam logic [4:0] StRec   = 5'b00010;
  localparam logic [4:0] StStop  = 5'b00100;
  localparam logic [4:0] StShift = 5'b01000;
  localparam logic [4:0] StPlay  = 5'b10000;

  logic [4:0]        state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic              full_q, full_d;
  logic [PW-1:0]     p_q, p_d;
  logic              shift_start_q, shift_start_d;
  logic [DATA_W-1:0] audio_out_q;
  logic              out_valid_q;

  logic              we;
  logic              re;
  logic [PW:0]       p_sum;
  logic [PW:0]       p_wrap;
  logic [PW:0]       len_fx;
  logic [ADDR_W-1:0] raddr;

  logic [DATA_W-1:0] mem_q [Depth];

  // One extra bit keeps P + Rate from overflowing before it is compared with Length.
  assign len_fx = {1'b0, length_q, {FRAC_W{1'b0}}};
  assign p_sum  = {1'b0, p_q} + {{(PW - FRAC_W - 1){1'b0}}, bus.Rate};
  assign p_wrap = p_sum - len_fx;
  assign raddr  = p_q[FRAC_W +: ADDR_W];

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    length_d = length_q;
    full_d   = full_q;
    p_d      = p_q;
    we       = 1'b0;
    re       = 1'b0;
    unique case (state_q)
      StI: begin
        if (bus.Rec) begin
          state_d = StRec;
          wptr_d  = '0;
        end else if (bus.Play && (length_q != '0)) begin
          state_d = StShift;
        end
      end
      StRec: begin
        if (bus.Sample_En) begin
          we     = 1'b1;
          wptr_d = wptr_q + 1'b1;
        end
        if (bus.Sample_En && (wptr_q == {ADDR_W{1'b1}})) begin
          // The last address was written: stop instead of wrapping.
          state_d  = StStop;
          length_d = {1'b1, {ADDR_W{1'b0}}};
          full_d   = 1'b1;
        end else if (bus.Stop) begin
          state_d  = StStop;
          length_d = {1'b0, wptr_q} + {{ADDR_W{1'b0}}, bus.Sample_En};
        end
      end
      StStop: begin
        if (bus.Rec) begin
          state_d = StRec;
          wptr_d  = '0;
          full_d  = 1'b0;
        end else if (bus.Play && (length_q != '0)) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.Stop) begin
          state_d = StStop;
        end else if (bus.Shift_Done) begin
          state_d = StPlay;
          p_d     = '0;
        end
      end
      StPlay: begin
        if (bus.Stop) begin
          state_d = StStop;
        end else if (bus.Sample_En) begin
          re = 1'b1;
          if (p_sum < len_fx) begin
            p_d = p_sum[PW-1:0];
          end else if (bus.Loop) begin
            // A very short buffer can still be past the end after one wrap.
            p_d = (p_wrap < len_fx) ? p_wrap[PW-1:0] : '0;
          end else begin
            state_d = StStop;
          end
        end
      end
      default: state_d = StI;
    endcase
    shift_start_d = (state_d == StShift) && (state_q != StShift);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= StI;
      wptr_q        <= '0;
      length_q      <= '0;
      full_q        <= 1'b0;
      p_q           <= '0;
      shift_start_q <= 1'b0;
      audio_out_q   <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      length_q      <= length_d;
      full_q        <= full_d;
      p_q           <= p_d;
      shift_start_q <= shift_start_d;
      out_valid_q   <= re;
      if (re) begin
        audio_out_q <= mem_q[raddr];
      end
    end
  end

  // Sample storage is not reset.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem_q[wptr_q] <= bus.Audio_In;
    end
  end

  assign bus.Shift_Start = shift_start_q;
  assign bus.Audio_Out   = audio_out_q;
  assign bus.Out_Valid   = out_valid_q;
  assign bus.Length      = length_q;
  assign bus.Full        = full_q;
  assign bus.q_I         = state_q[0];
  assign bus.q_Rec       = state_q[1];
  assign bus.q_Stop      = state_q[2];
  assign bus.q_Shift     = state_q[3];
  assign bus.q_Play      = state_q[4];

endmodule

// File: tb/tb_veritune_recorder.sv
// tb_veritune_recorder: directed stimulus with a scoreboard. Expected playback samples are
// queued when Sample_En is issued. A negedge monitor pops one entry per Out_Valid pulse.
module tb_veritune_recorder;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned FW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  veritune_recorder_if #(.DATA_W(DW), .ADDR_W(AW), .FRAC_W(FW)) bus ();

  veritune_recorder #(.DATA_W(DW), .ADDR_W(AW), .FRAC_W(FW)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ss_cnt = 0;
  int ss0;
  logic [DW-1:0] exp_q[$];

  int pat_half[10] = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1};
  int pat_two4[4]  = '{1, 3, 1, 3};
  int pat_two3[4]  = '{7, 9, 8, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.Shift_Start === 1'b1) ss_cnt++;
    if (bus.Out_Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got Audio_Out %0d, expected no output", bus.Audio_Out);
      end else begin
        automatic logic [DW-1:0] e = exp_q.pop_front();
        chk("audio_out", {16'd0, bus.Audio_Out}, {16'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec_samples(input int first, input int n, input bit stop_last);
    for (int i = 0; i < n; i++) begin
      bus.Sample_En = 1'b1;
      bus.Audio_In  = DW'(first + i);
      bus.Stop      = stop_last && (i == n - 1);
      tick();
    end
    bus.Sample_En = 1'b0;
    bus.Stop      = 1'b0;
  endtask

  task automatic start_rec();
    bus.Rec = 1'b1;
    tick();
    bus.Rec = 1'b0;
    chk("q_rec_after_rec", bus.q_Rec, 1);
  endtask

  task automatic start_play();
    ss0 = ss_cnt;
    bus.Play = 1'b1;
    tick();
    bus.Play = 1'b0;
    chk("q_shift_after_play", bus.q_Shift, 1);
    chk("shift_start_first", bus.Shift_Start, 1);
    repeat (6) tick();
    bus.Shift_Done = 1'b1;
    tick();
    bus.Shift_Done = 1'b0;
    chk("q_play_after_done", bus.q_Play, 1);
    chk("shift_start_pulses", ss_cnt - ss0, 1);
  endtask

  task automatic se_play(input int e);
    exp_q.push_back(DW'(e));
    bus.Sample_En = 1'b1;
    tick();
    bus.Sample_En = 1'b0;
    chk("out_valid_latency", bus.Out_Valid, 1);
    tick();
  endtask

  task automatic stop_cmd();
    bus.Stop = 1'b1;
    tick();
    bus.Stop = 1'b0;
    chk("q_stop_after_stop", bus.q_Stop, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q_i"}, bus.q_I, 1);
    chk({tag, "_length"}, bus.Length, 0);
    chk({tag, "_full"}, bus.Full, 0);
    chk({tag, "_audio_out"}, bus.Audio_Out, 0);
    chk({tag, "_out_valid"}, bus.Out_Valid, 0);
    chk({tag, "_shift_start"}, bus.Shift_Start, 0);
  endtask

  initial begin
    bus.Rec = 0; bus.Stop = 0; bus.Play = 0; bus.Loop = 0; bus.Sample_En = 0;
    bus.Audio_In = '0; bus.Rate = 10'd256; bus.Shift_Done = 0;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    #1 rst_n = 1'b1;
    tick();

    // Length 5, then reset in the middle of a new recording.
    start_rec();
    rec_samples(11, 5, 1'b1);
    chk("len5", bus.Length, 5);
    start_rec();
    rec_samples(21, 2, 1'b0);
    rst_n = 1'b0;
    #1 chk_reset_vals("midrec");
    #1 rst_n = 1'b1;
    tick();
    bus.Play = 1'b1;
    tick();
    bus.Play = 1'b0;
    chk("play_ignored_len0", bus.q_I, 1);

    // 10 samples with Stop on the last strobe, then one-shot playback at 1.0.
    start_rec();
    rec_samples(1, 10, 1'b1);
    chk("len10", bus.Length, 10);
    chk("q_stop_len10", bus.q_Stop, 1);
    bus.Loop = 1'b0;
    bus.Rate = 10'd256;
    start_play();
    for (int i = 1; i <= 10; i++) se_play(i);
    chk("oneshot_end_stop", bus.q_Stop, 1);

    // Length 4, looped at 0.5 and 2.0.
    start_rec();
    rec_samples(1, 4, 1'b1);
    chk("len4", bus.Length, 4);
    bus.Loop = 1'b1;
    bus.Rate = 10'd128;
    start_play();
    for (int i = 0; i < 10; i++) se_play(pat_half[i]);
    bus.Stop = 1'b1;
    bus.Sample_En = 1'b1;
    tick();
    bus.Stop = 1'b0;
    bus.Sample_En = 1'b0;
    chk("stop_with_se_state", bus.q_Stop, 1);
    chk("stop_with_se_no_valid", bus.Out_Valid, 0);
    tick();
    bus.Rate = 10'd512;
    start_play();
    for (int i = 0; i < 4; i++) se_play(pat_two4[i]);
    stop_cmd();

    // Rec beats Play in STOP; Stop beats Shift_Done in SHIFT.
    ss0 = ss_cnt;
    bus.Rec = 1'b1;
    bus.Play = 1'b1;
    tick();
    bus.Rec = 1'b0;
    bus.Play = 1'b0;
    chk("rec_prio_state", bus.q_Rec, 1);
    tick();
    chk("rec_prio_no_shift", ss_cnt - ss0, 0);
    rec_samples(7, 3, 1'b1);
    chk("len3", bus.Length, 3);
    bus.Play = 1'b1;
    tick();
    bus.Play = 1'b0;
    chk("shift_entered", bus.q_Shift, 1);
    bus.Stop = 1'b1;
    bus.Shift_Done = 1'b1;
    tick();
    bus.Stop = 1'b0;
    bus.Shift_Done = 1'b0;
    chk("stop_prio_shift", bus.q_Stop, 1);
    bus.Shift_Done = 1'b1;
    tick();
    bus.Shift_Done = 1'b0;
    chk("late_done_ignored", bus.q_Stop, 1);
    bus.Rate = 10'd512;
    start_play();
    for (int i = 0; i < 4; i++) se_play(pat_two3[i]);
    stop_cmd();

    // Fill the buffer with back-to-back strobes.
    start_rec();
    for (int i = 0; i < 20; i++) begin
      bus.Sample_En = 1'b1;
      bus.Audio_In  = DW'(101 + i);
      tick();
    end
    bus.Sample_En = 1'b0;
    chk("full_state", bus.q_Stop, 1);
    chk("full_length", bus.Length, 16);
    chk("full_flag", bus.Full, 1);
    bus.Loop = 1'b0;
    bus.Rate = 10'd256;
    start_play();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(DW'(101 + i));
      bus.Sample_En = 1'b1;
      tick();
    end
    bus.Sample_En = 1'b0;
    chk("full_play_end", bus.q_Stop, 1);
    bus.Loop = 1'b1;
    bus.Rate = 10'd0;
    start_play();
    for (int i = 0; i < 3; i++) se_play(101);
    stop_cmd();
    start_rec();
    chk("full_cleared", bus.Full, 0);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
